// File: rtl/multi_cycle_controller_pkg.sv
// Shared constants for the multi-cycle MIPS-subset controller: FSM states,
// opcode/funct codes, ALU control codes and the control-line bundle.
package multi_cycle_controller_pkg;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_EX_I, S_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_R, S_WB_I, S_WB_MEM, S_BR, S_JMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_dst;
    logic       jal_reg;
    logic       pc_to_reg;
    logic       alu_src;
    logic       mem_to_reg;
    logic       jump_sel;
    logic       pc_jump;
    logic       pc_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] alu_cntrl;
    logic       illegal_instr;
  } ctl_t;

endpackage

// File: rtl/multi_cycle_controller_alu_op_decoder.sv
// ALU operation decoder: maps opcode class and funct to alu_cntrl and flags
// R-type funct codes that are not ALU operations.
module alu_op_decoder
  import multi_cycle_controller_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_cntrl,
  output logic       not_alu_funct
);

  always_comb begin
    alu_cntrl     = ALU_ADD;
    not_alu_funct = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   alu_cntrl = ALU_ADD;
          F_SUB:   alu_cntrl = ALU_SUB;
          F_AND:   alu_cntrl = ALU_AND;
          F_OR:    alu_cntrl = ALU_OR;
          F_SLT:   alu_cntrl = ALU_SLT;
          default: not_alu_funct = 1'b1;
        endcase
      end
      OP_SLTI: alu_cntrl = ALU_SLT;
      OP_BEQ:  alu_cntrl = ALU_SUB;
      default: alu_cntrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle control FSM for the MIPS-subset core. Optional retired-instruction
// counter is built only when RETIRE_CNT_EN is defined; otherwise retired_cnt is 0.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        jal_reg,
  output logic        pc_to_reg,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        jump_sel,
  output logic        pc_jump,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  alu_cntrl,
  output logic        illegal_instr,
  output logic [31:0] retired_cnt
);

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d, funct_q, funct_d;
  logic [2:0] dec_alu;
  logic       dec_not_alu;
  ctl_t       ctl, ctl_out;

  // Opcode/funct are captured during decode; later states see only the copy.
  always_comb begin
    op_d    = op_q;
    funct_d = funct_q;
    if (state_q == S_ID) begin
      op_d    = opcode;
      funct_d = funct;
    end
  end

  alu_op_decoder u_alu_dec (
    .opcode        (op_d),
    .funct         (funct_d),
    .alu_cntrl     (dec_alu),
    .not_alu_funct (dec_not_alu)
  );

  // Memory handshake: mem_read/mem_write is the request and stays asserted,
  // unchanged, every cycle until the cycle in which mem_ready is sampled high.
  always_comb begin
    state_d       = state_q;
    ctl           = '0;
    ctl.alu_cntrl = ALU_ADD;
    case (state_q)
      S_IF: begin
        ctl.mem_read = 1'b1;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = S_ID;
        end
      end
      S_ID: begin
        state_d = S_IF;
        case (opcode)
          OP_RTYPE: begin
            if (funct == F_JR)     state_d = S_JMP;
            else if (!dec_not_alu) state_d = S_EX_R;
            else                   ctl.illegal_instr = 1'b1;
          end
          OP_ADDI, OP_SLTI: state_d = S_EX_I;
          OP_LW, OP_SW:     state_d = S_ADDR;
          OP_BEQ:           state_d = S_BR;
          OP_J, OP_JAL:     state_d = S_JMP;
          default:          ctl.illegal_instr = 1'b1;
        endcase
      end
      S_EX_R: begin
        ctl.alu_cntrl = dec_alu;
        state_d       = S_WB_R;
      end
      S_EX_I: begin
        ctl.alu_src   = 1'b1;
        ctl.alu_cntrl = dec_alu;
        state_d       = S_WB_I;
      end
      S_ADDR: begin
        ctl.alu_src = 1'b1;
        state_d     = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        ctl.mem_write = 1'b1;
        if (mem_ready) state_d = S_IF;
      end
      S_WB_R: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
        state_d       = S_IF;
      end
      S_WB_I: begin
        ctl.reg_write = 1'b1;
        state_d       = S_IF;
      end
      S_WB_MEM: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        state_d        = S_IF;
      end
      S_BR: begin
        ctl.alu_cntrl = ALU_SUB;
        ctl.pc_write  = zero;
        ctl.pc_src    = 1'b1;
        state_d       = S_IF;
      end
      S_JMP: begin
        ctl.pc_write = 1'b1;
        ctl.pc_jump  = 1'b1;
        ctl.jump_sel = (op_q != OP_RTYPE);
        if (op_q == OP_JAL) begin
          ctl.reg_write = 1'b1;
          ctl.jal_reg   = 1'b1;
          ctl.pc_to_reg = 1'b1;
        end
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Reset silences every control line, not just the state register.
  assign ctl_out = rst ? '0 : ctl;

  assign pc_write      = ctl_out.pc_write;
  assign ir_write      = ctl_out.ir_write;
  assign reg_dst       = ctl_out.reg_dst;
  assign jal_reg       = ctl_out.jal_reg;
  assign pc_to_reg     = ctl_out.pc_to_reg;
  assign alu_src       = ctl_out.alu_src;
  assign mem_to_reg    = ctl_out.mem_to_reg;
  assign jump_sel      = ctl_out.jump_sel;
  assign pc_jump       = ctl_out.pc_jump;
  assign pc_src        = ctl_out.pc_src;
  assign reg_write     = ctl_out.reg_write;
  assign mem_read      = ctl_out.mem_read;
  assign mem_write     = ctl_out.mem_write;
  assign alu_cntrl     = ctl_out.alu_cntrl;
  assign illegal_instr = ctl_out.illegal_instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
    end
  end

`ifdef RETIRE_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        retire;

  // Final cycle of every legal instruction; branch outcome does not matter.
  assign retire = (state_q == S_WB_R) || (state_q == S_WB_I) ||
                  (state_q == S_WB_MEM) || (state_q == S_BR) ||
                  (state_q == S_JMP) || ((state_q == S_MEM_WR) && mem_ready);

  always_comb begin
    cnt_d = cnt_q;
    if (retire) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign retired_cnt = cnt_q;
`else
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: per-instruction cycle
// expectations built from the instruction-level rules, checked every cycle.
module tb_multi_cycle_controller;

  localparam int W = 49;
`ifdef RETIRE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam logic [16:0] PCW  = 17'h10000;
  localparam logic [16:0] IRW  = 17'h08000;
  localparam logic [16:0] RDST = 17'h04000;
  localparam logic [16:0] JALR = 17'h02000;
  localparam logic [16:0] P2R  = 17'h01000;
  localparam logic [16:0] ASRC = 17'h00800;
  localparam logic [16:0] MTR  = 17'h00400;
  localparam logic [16:0] JSEL = 17'h00200;
  localparam logic [16:0] PCJ  = 17'h00100;
  localparam logic [16:0] PCS  = 17'h00080;
  localparam logic [16:0] RW   = 17'h00040;
  localparam logic [16:0] MRD  = 17'h00020;
  localparam logic [16:0] MWR  = 17'h00010;
  localparam logic [16:0] ILL  = 17'h00001;
  localparam logic [16:0] A_AND = 17'h0;
  localparam logic [16:0] A_OR  = 17'h2;
  localparam logic [16:0] A_ADD = 17'h4;
  localparam logic [16:0] A_SUB = 17'hC;
  localparam logic [16:0] A_SLT = 17'hE;

  logic        clk, rst;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_write, ir_write, reg_dst, jal_reg, pc_to_reg, alu_src;
  logic        mem_to_reg, jump_sel, pc_jump, pc_src, reg_write, mem_read, mem_write;
  logic [2:0]  alu_cntrl;
  logic        illegal_instr;
  logic [31:0] retired_cnt;

  logic [W-1:0] exp_q[$];
  logic [31:0]  model_cnt;
  int           total, bad;

  logic [5:0] tbl_op[13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h23, 6'h2B, 6'h04, 6'h08, 6'h0A, 6'h02, 6'h03};
  logic [5:0] tbl_fn[13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  multi_cycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .jal_reg(jal_reg), .pc_to_reg(pc_to_reg),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .jump_sel(jump_sel),
    .pc_jump(pc_jump), .pc_src(pc_src), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_cntrl(alu_cntrl),
    .illegal_instr(illegal_instr), .retired_cnt(retired_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
                    (fn == 6'h25) || (fn == 6'h2A) || (fn == 6'h08);
      6'h23, 6'h2B, 6'h04, 6'h08, 6'h0A, 6'h02, 6'h03: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [16:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return A_SUB;
      6'h24:   return A_AND;
      6'h25:   return A_OR;
      6'h2A:   return A_SLT;
      default: return A_ADD;
    endcase
  endfunction

  function automatic logic [31:0] exp_cnt();
    return CNT_ON ? model_cnt : 32'd0;
  endfunction

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  // Driver: one cycle with given inputs and the control lines expected in it
  task automatic step(input logic [16:0] c, input logic rdy, input logic z);
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back({exp_cnt(), c});
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int if_wait, input int mem_wait, input logic z);
    logic        legal;
    logic [16:0] c;
    legal = is_legal(op, fn);
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    for (int i = 0; i < if_wait; i++) step(MRD | A_ADD, 1'b0, rnd1());
    step(MRD | IRW | PCW | A_ADD, 1'b1, rnd1());
    opcode = op;
    funct  = fn;
    step(A_ADD | (legal ? 17'h0 : ILL), rnd1(), rnd1());
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    if (!legal) return;
    if (op == 6'h00 && fn != 6'h08) begin
      step(r_alu(fn), rnd1(), rnd1());
      step(RDST | RW | A_ADD, rnd1(), rnd1());
    end else if (op == 6'h08 || op == 6'h0A) begin
      step(ASRC | ((op == 6'h0A) ? A_SLT : A_ADD), rnd1(), rnd1());
      step(RW | A_ADD, rnd1(), rnd1());
    end else if (op == 6'h23) begin
      step(ASRC | A_ADD, rnd1(), rnd1());
      for (int i = 0; i < mem_wait; i++) step(MRD | A_ADD, 1'b0, rnd1());
      step(MRD | A_ADD, 1'b1, rnd1());
      step(MTR | RW | A_ADD, rnd1(), rnd1());
    end else if (op == 6'h2B) begin
      step(ASRC | A_ADD, rnd1(), rnd1());
      for (int i = 0; i < mem_wait; i++) step(MWR | A_ADD, 1'b0, rnd1());
      step(MWR | A_ADD, 1'b1, rnd1());
    end else if (op == 6'h04) begin
      step(A_SUB | PCS | (z ? PCW : 17'h0), rnd1(), z);
    end else begin
      c = PCW | PCJ | A_ADD;
      if (op != 6'h00) c = c | JSEL;
      if (op == 6'h03) c = c | RW | JALR | P2R;
      step(c, rnd1(), rnd1());
    end
    model_cnt = model_cnt + 32'd1;
  endtask

  // Scoreboard: compare every cycle that has an expectation queued
  always @(negedge clk) begin
    logic [W-1:0] e, act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {retired_cnt, pc_write, ir_write, reg_dst, jal_reg, pc_to_reg,
             alu_src, mem_to_reg, jump_sel, pc_jump, pc_src, reg_write,
             mem_read, mem_write, alu_cntrl, illegal_instr};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL cycle_ctl t=%0t got=%h want=%h", $time, act, e);
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    model_cnt = 32'd0;
    rst = 1'b1;
    opcode = '0;
    funct = '0;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(17'h0, 1'b1, 1'b1);
    step(17'h0, 1'b0, 1'b0);
    rst = 1'b0;

    run_instr(6'h00, 6'h20, 0, 0, 1'b0);
    lit("add_retired", retired_cnt, CNT_ON ? 32'd1 : 32'd0);
    run_instr(6'h23, 6'h00, 0, 3, 1'b0);
    run_instr(6'h04, 6'h00, 0, 0, 1'b1);
    run_instr(6'h04, 6'h00, 0, 0, 1'b0);
    lit("beq_retired", retired_cnt, CNT_ON ? 32'd4 : 32'd0);
    run_instr(6'h03, 6'h00, 1, 0, 1'b0);
    run_instr(6'h00, 6'h08, 0, 0, 1'b0);
    run_instr(6'h3F, 6'h00, 2, 0, 1'b0);
    lit("illegal_retired", retired_cnt, CNT_ON ? 32'd6 : 32'd0);

    // Reset while a store is waiting on memory
    opcode = 6'($urandom);
    step(MRD | IRW | PCW | A_ADD, 1'b1, 1'b0);
    opcode = 6'h2B;
    step(A_ADD, 1'b1, 1'b0);
    opcode = 6'($urandom);
    step(ASRC | A_ADD, 1'b1, 1'b0);
    step(MWR | A_ADD, 1'b0, 1'b0);
    step(MWR | A_ADD, 1'b0, 1'b0);
    rst = 1'b1;
    model_cnt = 32'd0;
    step(17'h0, 1'b1, 1'b0);
    step(17'h0, 1'b1, 1'b1);
    rst = 1'b0;
    lit("reset_retired", retired_cnt, 32'd0);
    run_instr(6'h2B, 6'h00, 0, 1, 1'b0);
    lit("after_reset_retired", retired_cnt, CNT_ON ? 32'd1 : 32'd0);

    for (int n = 0; n < 300; n++) begin
      int idx;
      logic [5:0] op, fn;
      idx = $urandom_range(0, 15);
      if (idx < 13) begin
        op = tbl_op[idx];
        fn = tbl_fn[idx];
      end else begin
        op = (idx == 15) ? 6'h00 : 6'($urandom);
        fn = 6'($urandom);
      end
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), rnd1());
    end
    lit("final_retired", retired_cnt, exp_cnt());

    repeat (3) @(posedge clk);
    lit("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
